// File: rtl/dapuf_eval_ctrl.sv
// Evaluation sequencer for the DAPUF core: holds a challenge, fires NUM_EVAL
// excite pulses with settle/relax gaps, and majority-votes the synchronised response.
module dapuf_eval_ctrl #(
  parameter int CHAL_W     = 16,
  parameter int SETTLE_CYC = 8,
  parameter int NUM_EVAL   = 15,
  parameter int CNT_W      = $clog2(NUM_EVAL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chal_valid,
  output logic              chal_ready,
  input  logic [CHAL_W-1:0] chal_data,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_excite_l,
  output logic              puf_excite_r,
  input  logic              puf_response,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
  output logic [CNT_W-1:0]  resp_ones,
  output logic              resp_stable
);

  localparam int TMR_W = $clog2(SETTLE_CYC + 2);
  localparam logic [TMR_W-1:0] APPLY_LAST = TMR_W'(SETTLE_CYC);
  localparam logic [TMR_W-1:0] FIRE_LAST  = TMR_W'(SETTLE_CYC + 1);
  localparam logic [TMR_W-1:0] RELAX_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] EVAL_MAX   = CNT_W'(NUM_EVAL);
  localparam logic [CNT_W-1:0] HALF       = CNT_W'(NUM_EVAL / 2);

  typedef enum logic [2:0] {IDLE, APPLY, FIRE, RELAX, DONE} state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  eval_q, eval_d;
  logic [CNT_W-1:0]  ones_q, ones_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic              excite_q, excite_d;
  logic [1:0]        sync_q;
  logic              rbit_q, rbit_d;
  logic [CNT_W-1:0]  rones_q, rones_d;
  logic              rstable_q, rstable_d;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    eval_d    = eval_q;
    ones_d    = ones_q;
    chal_d    = chal_q;
    rbit_d    = rbit_q;
    rones_d   = rones_q;
    rstable_d = rstable_q;
    case (state_q)
      IDLE: begin
        if (chal_valid) begin
          chal_d  = chal_data;
          timer_d = '0;
          eval_d  = '0;
          ones_d  = '0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (timer_q == APPLY_LAST) begin
          timer_d = '0;
          state_d = FIRE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      // The synchroniser output is only trusted on the final FIRE cycle.
      FIRE: begin
        if (timer_q == FIRE_LAST) begin
          timer_d = '0;
          eval_d  = eval_q + 1'b1;
          if (sync_q[1] && (ones_q != EVAL_MAX)) ones_d = ones_q + 1'b1;
          state_d = RELAX;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RELAX: begin
        if (timer_q == RELAX_LAST) begin
          timer_d = '0;
          if (eval_q < EVAL_MAX) begin
            state_d = FIRE;
          end else begin
            rones_d   = ones_q;
            rbit_d    = (ones_q > HALF);
            rstable_d = (ones_q == '0) || (ones_q == EVAL_MAX);
            state_d   = DONE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    excite_d = (state_d == FIRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      eval_q    <= '0;
      ones_q    <= '0;
      chal_q    <= '0;
      excite_q  <= 1'b0;
      sync_q    <= '0;
      rbit_q    <= 1'b0;
      rones_q   <= '0;
      rstable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      eval_q    <= eval_d;
      ones_q    <= ones_d;
      chal_q    <= chal_d;
      excite_q  <= excite_d;
      sync_q    <= {sync_q[0], puf_response};
      rbit_q    <= rbit_d;
      rones_q   <= rones_d;
      rstable_q <= rstable_d;
    end
  end

  // Both arbiter inputs come from one flop so their edges are coincident.
  assign puf_excite_l  = excite_q;
  assign puf_excite_r  = excite_q;
  assign puf_challenge = chal_q;
  assign chal_ready    = (state_q == IDLE);
  assign resp_valid    = (state_q == DONE);
  assign resp_bit      = rbit_q;
  assign resp_ones     = rones_q;
  assign resp_stable   = rstable_q;

endmodule

// File: tb/tb_dapuf_eval_ctrl.sv
// Self-checking bench for dapuf_eval_ctrl: table vectors, random patterns
// against a popcount/majority model, and hand-written multi-cycle sequences.
module tb_dapuf_eval_ctrl;

  localparam int S   = 8;
  localparam int N   = 15;
  localparam int CW  = $clog2(N + 1);
  localparam int LAT = 1 + S + N * (2 * S + 2);

  localparam int S2   = 1;
  localparam int N2   = 4;
  localparam int CW2  = $clog2(N2 + 1);
  localparam int LAT2 = 1 + S2 + N2 * (2 * S2 + 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          chal_valid, chal_ready, resp_valid, resp_ready;
  logic [15:0]   chal_data, puf_challenge;
  logic          puf_excite_l, puf_excite_r, resp_bit, resp_stable;
  logic          puf_response = 1'b0;
  logic [CW-1:0] resp_ones;

  logic           chal_valid2, chal_ready2, resp_valid2, resp_ready2;
  logic [15:0]    chal_data2, puf_challenge2;
  logic           puf_excite_l2, puf_excite_r2, resp_bit2, resp_stable2;
  logic           puf_response2 = 1'b0;
  logic [CW2-1:0] resp_ones2;

  dapuf_eval_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .chal_valid(chal_valid), .chal_ready(chal_ready), .chal_data(chal_data),
    .puf_challenge(puf_challenge), .puf_excite_l(puf_excite_l), .puf_excite_r(puf_excite_r),
    .puf_response(puf_response), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_bit(resp_bit), .resp_ones(resp_ones), .resp_stable(resp_stable)
  );

  dapuf_eval_ctrl #(.CHAL_W(16), .SETTLE_CYC(S2), .NUM_EVAL(N2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .chal_valid(chal_valid2), .chal_ready(chal_ready2), .chal_data(chal_data2),
    .puf_challenge(puf_challenge2), .puf_excite_l(puf_excite_l2), .puf_excite_r(puf_excite_r2),
    .puf_response(puf_response2), .resp_valid(resp_valid2), .resp_ready(resp_ready2),
    .resp_bit(resp_bit2), .resp_ones(resp_ones2), .resp_stable(resp_stable2)
  );

  // PUF models: evaluation k (counted from 0 per challenge) answers curPat[k]
  logic [31:0] curPat = '0;
  logic [31:0] curPat2 = '0;
  int evalIdx = 0, evalIdx2 = 0;
  logic exPrev = 1'b0, exPrev2 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n || chal_ready) evalIdx = 0;
    else if (puf_excite_l && !exPrev) begin
      puf_response = (evalIdx < 32) ? curPat[evalIdx] : 1'b0;
      evalIdx++;
    end
    exPrev = puf_excite_l;
  end

  always @(negedge clk) begin
    if (!rst_n || chal_ready2) evalIdx2 = 0;
    else if (puf_excite_l2 && !exPrev2) begin
      puf_response2 = (evalIdx2 < 32) ? curPat2[evalIdx2] : 1'b0;
      evalIdx2++;
    end
    exPrev2 = puf_excite_l2;
  end

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int refOnes(input logic [31:0] pat, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(pat[i]);
    return c;
  endfunction

  // Runs one challenge up to DONE (no response handshake) and checks the result.
  task automatic applyStimulus(input logic [15:0] chal, input logic [31:0] pat,
                               input int expOnes, input logic expBit, input logic expStable);
    int edgeN, riseEdge, fallEdge, pulses, badShape, badBusy;
    logic prevEx, done;
    curPat = pat;
    @(negedge clk);
    chal_valid = 1'b1;
    chal_data  = chal;
    checkOutput("chal_ready_idle", chal_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("puf_challenge_latch", puf_challenge, chal);
    edgeN = 0; riseEdge = 0; fallEdge = -1; pulses = 0; badShape = 0; badBusy = 0;
    prevEx = 1'b0; done = 1'b0;
    while (!done && edgeN < LAT + 100) begin
      chal_valid = 1'($urandom);
      chal_data  = 16'($urandom);
      @(posedge clk);
      #1;
      edgeN++;
      if (puf_excite_l !== puf_excite_r || puf_challenge !== chal) badBusy++;
      if (puf_excite_l && !prevEx) begin
        pulses++;
        if (fallEdge < 0) begin
          if (edgeN != S + 1) badShape++;
        end else if (edgeN - fallEdge != S) badShape++;
        riseEdge = edgeN;
      end
      if (!puf_excite_l && prevEx) begin
        fallEdge = edgeN;
        if (edgeN - riseEdge != S + 2) badShape++;
      end
      prevEx = puf_excite_l;
      if (resp_valid === 1'b1) done = 1'b1;
      else if (chal_ready !== 1'b0) badBusy++;
    end
    chal_valid = 1'b0;
    checkOutput("resp_valid_edge", edgeN, LAT);
    checkOutput("excite_pulse_count", pulses, N);
    checkOutput("excite_shape_errors", badShape, 0);
    checkOutput("busy_errors", badBusy, 0);
    checkOutput("resp_ones", resp_ones, expOnes);
    checkOutput("resp_bit", resp_bit, expBit);
    checkOutput("resp_stable", resp_stable, expStable);
  endtask

  task automatic handshake();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checkOutput("idle_after_handshake", chal_ready, 1);
    checkOutput("resp_valid_after_handshake", resp_valid, 0);
  endtask

  typedef struct {
    logic [15:0] chal;
    logic [31:0] pat;
    int          expOnes;
    logic        expBit;
    logic        expStable;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bad, ones;
    logic [31:0] rp;
    logic [15:0] rc;

    vecs[0] = '{16'hA5C3, 32'h0000_7FFF, 15, 1'b1, 1'b1};
    vecs[1] = '{16'h1357, 32'h0000_007F,  7, 1'b0, 1'b0};
    vecs[2] = '{16'h2468, 32'h0000_00FF,  8, 1'b1, 1'b0};
    vecs[3] = '{16'hFFFF, 32'h0000_0000,  0, 1'b0, 1'b1};

    rst_n = 1'b0;
    chal_valid = 1'b0; chal_data = '0; resp_ready = 1'b0;
    chal_valid2 = 1'b0; chal_data2 = '0; resp_ready2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_puf_challenge", puf_challenge, 0);
    checkOutput("rst_excite", {puf_excite_l, puf_excite_r}, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_fields", {resp_bit, resp_stable, 4'(resp_ones)}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("chal_ready_after_reset", chal_ready, 1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].chal, vecs[i].pat, vecs[i].expOnes, vecs[i].expBit, vecs[i].expStable);
      handshake();
    end

    for (int i = 0; i < 3; i++) begin
      rp = $urandom & 32'h0000_7FFF;
      rc = 16'($urandom);
      ones = refOnes(rp, N);
      applyStimulus(rc, rp, ones, ones > N / 2, (ones == 0) || (ones == N));
      handshake();
    end

    // Backpressure: stall in DONE while chal_valid toggles
    applyStimulus(16'h3C5A, 32'h0000_5555, 8, 1'b1, 1'b0);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chal_valid = 1'($urandom);
      chal_data  = 16'($urandom);
      @(posedge clk);
      #1;
      if (chal_ready !== 1'b0 || resp_valid !== 1'b1 || resp_ones !== CW'(8) || resp_bit !== 1'b1 ||
          resp_stable !== 1'b0 || puf_excite_l !== 1'b0 || puf_excite_r !== 1'b0 ||
          puf_challenge !== 16'h3C5A) bad++;
    end
    checkOutput("backpressure_hold_errors", bad, 0);
    @(negedge clk);
    resp_ready = 1'b1;
    chal_valid = 1'b1;
    chal_data  = 16'h0F0F;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checkOutput("bp_idle_after_handshake", chal_ready, 1);
    checkOutput("bp_challenge_not_taken_in_done", puf_challenge, 16'h3C5A);
    checkOutput("bp_result_held_in_idle", resp_ones, 8);
    @(posedge clk);
    #1;
    chal_valid = 1'b0;
    checkOutput("bp_next_challenge_accepted", puf_challenge, 16'h0F0F);
    checkOutput("bp_busy_after_accept", chal_ready, 0);

    // Asynchronous reset in the middle of the first FIRE pulse
    for (int k = 0; k < 40 && puf_excite_l !== 1'b1; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("excite_high_before_reset", puf_excite_l, 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midfire_rst_excite", {puf_excite_l, puf_excite_r}, 0);
    checkOutput("midfire_rst_challenge", puf_challenge, 0);
    checkOutput("midfire_rst_resp", {resp_valid, resp_bit, resp_stable, 4'(resp_ones)}, 0);
    checkOutput("midfire_rst_chal_ready", chal_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'hBEEF, 32'h0000_4001, 2, 1'b0, 1'b0);
    handshake();

    // Small configuration: tie on an even evaluation count
    curPat2 = 32'h0000_0003;
    @(negedge clk);
    chal_valid2 = 1'b1;
    chal_data2  = 16'h1234;
    @(posedge clk);
    #1;
    chal_valid2 = 1'b0;
    checkOutput("cfg2_puf_challenge", puf_challenge2, 16'h1234);
    begin
      int e;
      e = 0;
      while (resp_valid2 !== 1'b1 && e < LAT2 + 50) begin
        @(posedge clk);
        #1;
        e++;
      end
      checkOutput("cfg2_resp_valid_edge", e, LAT2);
    end
    checkOutput("cfg2_resp_ones", resp_ones2, 2);
    checkOutput("cfg2_resp_bit_tie", resp_bit2, 0);
    checkOutput("cfg2_resp_stable", resp_stable2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
